// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Owns PC, IR, MBR and ACC; drives a req/ack word memory and a combinational ALU.
module cpu_control_unit #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [8:0]        alu_fn,
    output logic              alu_clr_acc,
    output logic              alu_clr_x,
    output logic [15:0]       alu_acc,
    output logic [15:0]       alu_x,
    input  logic [15:0]       alu_result,
    output logic [15:0]       acc_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal_op
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned OPC_W  = 8;
    localparam int unsigned FN_W   = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_OPRD, S_EXEC, S_STORE, S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   mbr_q, mbr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [OPC_W-1:0]    opc_q, opc_d;

    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [FN_W-1:0]     alu_fn_q, alu_fn_d;
    logic                clr_acc_q, clr_acc_d;
    logic                clr_x_q, clr_x_d;
    logic                halted_q, halted_d;
    logic                illegal_q, illegal_d;

    function automatic logic is_illegal(input logic [OPC_W-1:0] op);
        return (op == 8'h00) || (op > 8'h0F);
    endfunction

    assign opc_q = ir_q[15:8];
    assign opc_d = ir_d[15:8];

    // Next state and datapath registers; outputs are then decoded from the next state
    // so that every output is a flop that is valid for the whole state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mbr_d   = mbr_q;
        acc_d   = acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opc_q)
                    8'h01:                      state_d = S_STORE;
                    8'h02, 8'h03, 8'h04, 8'h08,
                    8'h09, 8'h0A, 8'h0B, 8'h0C: state_d = S_OPRD;
                    8'h0D, 8'h0E, 8'h0F:        state_d = S_EXEC;
                    8'h05: begin
                        if (!acc_q[15]) pc_d = ir_q[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end
                    8'h06: begin
                        pc_d    = ir_q[ADDR_W-1:0];
                        state_d = S_FETCH;
                    end
                    8'h07:                      state_d = S_HALT;
                    default:                    state_d = S_FETCH;
                endcase
            end
            S_OPRD: begin
                if (mem_ack) begin
                    mbr_d   = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_d   = alu_result;
                state_d = S_FETCH;
            end
            S_STORE: begin
                if (mem_ack) state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = RESET_PC;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mem_req_d  = (state_d == S_FETCH) || (state_d == S_OPRD) || (state_d == S_STORE);
        mem_we_d   = (state_d == S_STORE);
        mem_addr_d = '0;
        if (state_d == S_FETCH)
            mem_addr_d = pc_d;
        else if ((state_d == S_OPRD) || (state_d == S_STORE))
            mem_addr_d = ir_d[ADDR_W-1:0];
        alu_fn_d   = (state_d == S_EXEC) ? {1'b0, opc_d} : '0;
        clr_acc_d  = (state_d == S_EXEC) && ((opc_d == 8'h02) || (opc_d == 8'h0C));
        clr_x_d    = (state_d == S_EXEC) && (opc_d >= 8'h0D) && (opc_d <= 8'h0F);
        halted_d   = (state_d == S_HALT);
        illegal_d  = (state_d == S_DECODE) && is_illegal(opc_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            mbr_q      <= '0;
            acc_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            alu_fn_q   <= '0;
            clr_acc_q  <= 1'b0;
            clr_x_q    <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            mbr_q      <= mbr_d;
            acc_q      <= acc_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            alu_fn_q   <= alu_fn_d;
            clr_acc_q  <= clr_acc_d;
            clr_x_q    <= clr_x_d;
            halted_q   <= halted_d;
            illegal_q  <= illegal_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = acc_q;
    assign alu_fn      = alu_fn_q;
    assign alu_clr_acc = clr_acc_q;
    assign alu_clr_x   = clr_x_q;
    assign alu_acc     = acc_q;
    assign alu_x       = mbr_q;
    assign acc_out     = acc_q;
    assign pc_out      = pc_q;
    assign halted      = halted_q;
    assign illegal_op  = illegal_q;

endmodule
